fft_fsl_arbiter: RTL

Shares one `fft_coprocessor` between two MicroBlaze FSL channel pairs. The arbiter grants a requester one whole input frame of FRAME_LEN data words. It then routes exactly RESULT_LEN result words from the coprocessor back to that requester before arbitrating again. The block sits between the two processors' FSL FIFOs and the coprocessor's slave/master FSL ports. All data paths are combinational pass-through, gated by a registered frame state machine.

---
 rtl/fft_fsl_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fft_fsl_arbiter.sv
// Two-way FSL arbiter in front of a shared FFT coprocessor: one requester owns the
// coprocessor for a full input frame and its matching result frame.
module fft_fsl_arbiter #(
  parameter int FRAME_LEN  = 64,
  parameter int RESULT_LEN = 64
) (
  input  logic        FSL_Clk,
  input  logic        FSL_Rst,
  output logic        S0_Read,
  input  logic [0:31] S0_Data,
  input  logic        S0_Control,
  input  logic        S0_Exists,
  output logic        S1_Read,
  input  logic [0:31] S1_Data,
  input  logic        S1_Control,
  input  logic        S1_Exists,
  output logic        M0_Write,
  output logic [0:31] M0_Data,
  output logic        M0_Control,
  input  logic        M0_Full,
  output logic        M1_Write,
  output logic [0:31] M1_Data,
  output logic        M1_Control,
  input  logic        M1_Full,
  output logic        FFT_M_Write,
  output logic [0:31] FFT_M_Data,
  output logic        FFT_M_Control,
  input  logic        FFT_M_Full,
  output logic        FFT_S_Read,
  input  logic [0:31] FFT_S_Data,
  input  logic        FFT_S_Control,
  input  logic        FFT_S_Exists,
  output logic        Busy,
  output logic        Owner,
  output logic        Frame_Done
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  localparam logic [7:0] FRAME_LAST  = 8'(FRAME_LEN - 1);
  localparam logic [7:0] RESULT_LAST = 8'(RESULT_LEN - 1);

  state_t      state, state_d;
  logic        owner, owner_d;
  logic        last_grant, last_grant_d;
  logic [7:0]  cnt, cnt_d;
  logic        grantee;
  logic        src_exists, src_ctrl, dst_full;
  logic [0:31] src_data;
  logic        in_xfer, out_xfer;

  always_ff @(posedge FSL_Clk or negedge FSL_Rst) begin
    if (!FSL_Rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;   // requester 0 wins the first tie
      cnt        <= 8'd0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      last_grant <= last_grant_d;
      cnt        <= cnt_d;
    end
  end

  assign Busy  = (state != IDLE);
  assign Owner = owner;

  always_comb begin
    src_exists    = owner ? S1_Exists  : S0_Exists;
    src_ctrl      = owner ? S1_Control : S0_Control;
    src_data      = owner ? S1_Data    : S0_Data;
    dst_full      = owner ? M1_Full    : M0_Full;
    in_xfer       = (state == LOAD)  && src_exists   && !FFT_M_Full;
    out_xfer      = (state == DRAIN) && FFT_S_Exists && !dst_full;
    grantee       = (S0_Exists && S1_Exists) ? ~last_grant : S1_Exists;

    state_d       = state;
    owner_d       = owner;
    last_grant_d  = last_grant;
    cnt_d         = cnt;
    S0_Read       = 1'b0;
    S1_Read       = 1'b0;
    M0_Write      = 1'b0;
    M0_Data       = '0;
    M0_Control    = 1'b0;
    M1_Write      = 1'b0;
    M1_Data       = '0;
    M1_Control    = 1'b0;
    FFT_M_Write   = 1'b0;
    FFT_M_Data    = '0;
    FFT_M_Control = 1'b0;
    FFT_S_Read    = 1'b0;
    Frame_Done    = 1'b0;

    case (state)
      IDLE: begin
        if (S0_Exists || S1_Exists) begin
          owner_d      = grantee;
          last_grant_d = grantee;
          cnt_d        = 8'd0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        FFT_M_Data    = src_data;
        FFT_M_Control = src_ctrl;
        FFT_M_Write   = in_xfer;
        S0_Read       = in_xfer && !owner;
        S1_Read       = in_xfer &&  owner;
        // configuration words ride along without consuming frame slots
        if (in_xfer && !src_ctrl) begin
          if (cnt == FRAME_LAST) begin
            cnt_d   = 8'd0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end
      end
      DRAIN: begin
        FFT_S_Read = out_xfer;
        if (!owner) begin
          M0_Write   = out_xfer;
          M0_Data    = FFT_S_Data;
          M0_Control = FFT_S_Control;
        end else begin
          M1_Write   = out_xfer;
          M1_Data    = FFT_S_Data;
          M1_Control = FFT_S_Control;
        end
        if (out_xfer) begin
          if (cnt == RESULT_LAST) begin
            Frame_Done = 1'b1;
            cnt_d      = 8'd0;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
